// File: rtl/banked_mem.sv
// banked_mem: banked multi-port word memory with per-port valid/ready handshakes.
//
// Words are interleaved across NUM_BANKS banks: bank = addr[log2(NUM_BANKS)-1:0]
// and row = the bits above the bank field. Each bank serves one read and one
// write per cycle. Read and write arbitration are independent fixed-priority
// schemes in which the lowest port index wins. Reads are registered and return
// one cycle after acceptance. A write accepted in the same cycle to the same
// word is forwarded into the read (write-first). After reset the memory is
// cleared one row per cycle across all banks, and init_done then rises.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   o_init_done             high once the post-reset clear has finished
//   i_rd_valid/i_rd_addr    read requests, one per read port
//   o_rd_ready              read accepted this cycle (combinational)
//   o_rd_data               read data, registered, held between responses
//   o_rd_resp_valid         o_rd_data carries a response this cycle
//   o_rd_err                response was for an address >= DEPTH (data is 0)
//   i_wr_valid/i_wr_addr/
//   i_wr_data/i_wr_strb     write requests with byte enables
//   o_wr_ready              write accepted this cycle (combinational)
//   o_wr_err                accepted write was out of range and was dropped
module banked_mem #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int DEPTH           = 1024,
    parameter int NUM_BANKS       = 4,
    parameter int NUM_READ_PORTS  = 2,
    parameter int NUM_WRITE_PORTS = 2
) (
    input  logic                                             clk,
    input  logic                                             reset,
    output logic                                             o_init_done,
    input  logic [NUM_READ_PORTS-1:0]                        i_rd_valid,
    input  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]        i_rd_addr,
    output logic [NUM_READ_PORTS-1:0]                        o_rd_ready,
    output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]        o_rd_data,
    output logic [NUM_READ_PORTS-1:0]                        o_rd_resp_valid,
    output logic [NUM_READ_PORTS-1:0]                        o_rd_err,
    input  logic [NUM_WRITE_PORTS-1:0]                       i_wr_valid,
    input  logic [NUM_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]       i_wr_addr,
    input  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0]       i_wr_data,
    input  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH/8-1:0]     i_wr_strb,
    output logic [NUM_WRITE_PORTS-1:0]                       o_wr_ready,
    output logic [NUM_WRITE_PORTS-1:0]                       o_wr_err
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int ROWS   = DEPTH / NUM_BANKS;
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
    localparam logic [ROW_W-1:0]      LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                                    r_state;
    logic [ROW_W-1:0]                          r_init_row;
    logic                                      r_init_done;
    logic [DATA_WIDTH-1:0]                     r_mem [NUM_BANKS][ROWS];

    logic [NUM_READ_PORTS-1:0]                 r_rd_vld_p1;
    logic [NUM_READ_PORTS-1:0]                 r_rd_err_p1;
    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] r_rd_data_p1;

    logic                                      w_run;
    logic [NUM_READ_PORTS-1:0]                 w_rd_oor;
    logic [NUM_READ_PORTS-1:0][BANK_W-1:0]     w_rd_bank;
    logic [NUM_READ_PORTS-1:0][ROW_W-1:0]      w_rd_row;
    logic [NUM_READ_PORTS-1:0]                 w_rd_ready;
    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] w_rd_word;
    logic [NUM_WRITE_PORTS-1:0]                w_wr_oor;
    logic [NUM_WRITE_PORTS-1:0][BANK_W-1:0]    w_wr_bank;
    logic [NUM_WRITE_PORTS-1:0][ROW_W-1:0]     w_wr_row;
    logic [NUM_WRITE_PORTS-1:0]                w_wr_ready;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NBYTES-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < NBYTES; k++)
            if (strb[k]) res[8*k +: 8] = new_word[8*k +: 8];
        return res;
    endfunction

    // Gating with reset keeps every ready low in the reset cycle itself,
    // so nothing is accepted while the block is being reset.
    assign w_run = (r_state == S_RUN) && !reset;

    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            w_rd_oor[p]  = (i_rd_addr[p] >= DEPTH_A);
            w_rd_bank[p] = i_rd_addr[p][BANK_W-1:0];
            w_rd_row[p]  = i_rd_addr[p][BANK_W +: ROW_W];
        end
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            w_wr_oor[w]  = (i_wr_addr[w] >= DEPTH_A);
            w_wr_bank[w] = i_wr_addr[w][BANK_W-1:0];
            w_wr_row[w]  = i_wr_addr[w][BANK_W +: ROW_W];
        end
    end

    // Out-of-range requests never claim a bank, so they neither lose nor block.
    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            w_rd_ready[p] = w_run && i_rd_valid[p];
            if (!w_rd_oor[p])
                for (int q = 0; q < p; q++)
                    if (i_rd_valid[q] && !w_rd_oor[q] && (w_rd_bank[q] == w_rd_bank[p]))
                        w_rd_ready[p] = 1'b0;
        end
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            w_wr_ready[w] = w_run && i_wr_valid[w];
            if (!w_wr_oor[w])
                for (int q = 0; q < w; q++)
                    if (i_wr_valid[q] && !w_wr_oor[q] && (w_wr_bank[q] == w_wr_bank[w]))
                        w_wr_ready[w] = 1'b0;
        end
    end

    // Write-first: at most one write wins a bank, so at most one write can
    // match a given read address and be merged into the returned word.
    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            w_rd_word[p] = w_rd_oor[p] ? '0 : r_mem[w_rd_bank[p]][w_rd_row[p]];
            for (int w = 0; w < NUM_WRITE_PORTS; w++)
                if (w_wr_ready[w] && !w_wr_oor[w] && !w_rd_oor[p] &&
                    (w_wr_bank[w] == w_rd_bank[p]) && (w_wr_row[w] == w_rd_row[p]))
                    w_rd_word[p] = merge_bytes(w_rd_word[p], i_wr_data[w], i_wr_strb[w]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_INIT;
            r_init_row  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_init_row <= r_init_row + ROW_W'(1);
                    if (r_init_row == LAST_ROW) begin
                        r_state     <= S_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                S_RUN: r_state <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            for (int b = 0; b < NUM_BANKS; b++)
                r_mem[b][r_init_row] <= '0;
        end else begin
            for (int w = 0; w < NUM_WRITE_PORTS; w++)
                if (w_wr_ready[w] && !w_wr_oor[w])
                    r_mem[w_wr_bank[w]][w_wr_row[w]] <=
                        merge_bytes(r_mem[w_wr_bank[w]][w_wr_row[w]], i_wr_data[w], i_wr_strb[w]);
        end
    end

    // Read response stage: data only updates on acceptance so it holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_vld_p1  <= '0;
            r_rd_err_p1  <= '0;
            r_rd_data_p1 <= '0;
        end else begin
            r_rd_vld_p1 <= w_rd_ready;
            r_rd_err_p1 <= w_rd_ready & w_rd_oor;
            for (int p = 0; p < NUM_READ_PORTS; p++)
                if (w_rd_ready[p]) r_rd_data_p1[p] <= w_rd_word[p];
        end
    end

    assign o_init_done     = r_init_done;
    assign o_rd_ready      = w_rd_ready;
    assign o_rd_data       = r_rd_data_p1;
    assign o_rd_resp_valid = r_rd_vld_p1;
    assign o_rd_err        = r_rd_err_p1;
    assign o_wr_ready      = w_wr_ready;
    assign o_wr_err        = w_wr_ready & w_wr_oor;

endmodule

// File: tb/tb_banked_mem.sv
module tb_banked_mem;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int NB    = 4;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int ROWS  = DEPTH / NB;
    localparam int IDXW  = $clog2(DEPTH);

    logic clk = 1'b0;
    logic reset;
    logic init_done;
    logic [NR-1:0]          rd_valid;
    logic [NR-1:0][AW-1:0]  rd_addr;
    logic [NR-1:0]          rd_ready;
    logic [NR-1:0][DW-1:0]  rd_data;
    logic [NR-1:0]          rd_resp_valid;
    logic [NR-1:0]          rd_err;
    logic [NW-1:0]          wr_valid;
    logic [NW-1:0][AW-1:0]  wr_addr;
    logic [NW-1:0][DW-1:0]  wr_data;
    logic [NW-1:0][DW/8-1:0] wr_strb;
    logic [NW-1:0]          wr_ready;
    logic [NW-1:0]          wr_err;

    int checks = 0;
    int errors = 0;

    banked_mem #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_BANKS(NB),
        .NUM_READ_PORTS(NR), .NUM_WRITE_PORTS(NW)
    ) dut (
        .clk(clk), .reset(reset), .o_init_done(init_done),
        .i_rd_valid(rd_valid), .i_rd_addr(rd_addr), .o_rd_ready(rd_ready),
        .o_rd_data(rd_data), .o_rd_resp_valid(rd_resp_valid), .o_rd_err(rd_err),
        .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_wr_strb(wr_strb), .o_wr_ready(wr_ready), .o_wr_err(wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory as a flat word array, init as a cycle count,
    // write-first realised by applying the cycle's writes before its reads.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_cnt;
    bit            m_run;
    logic [NR-1:0] m_rvld, m_rerr;
    logic [DW-1:0] m_rdata [NR];

    initial begin : model
        logic [NR-1:0] e_rr;
        logic [NW-1:0] e_wr, e_we;
        bit            run_now, blocked;
        m_cnt = 0; m_run = 0; m_rvld = '0; m_rerr = '0;
        for (int p = 0; p < NR; p++) m_rdata[p] = '0;
        forever begin
            @(negedge clk);
            #4;
            run_now = m_run && !reset;
            for (int p = 0; p < NR; p++) begin
                blocked = 0;
                for (int q = 0; q < p; q++)
                    if (rd_valid[q] && rd_addr[q] < DEPTH && (rd_addr[q] % NB) == (rd_addr[p] % NB))
                        blocked = 1;
                e_rr[p] = run_now && rd_valid[p] && (rd_addr[p] >= DEPTH || !blocked);
            end
            for (int w = 0; w < NW; w++) begin
                blocked = 0;
                for (int q = 0; q < w; q++)
                    if (wr_valid[q] && wr_addr[q] < DEPTH && (wr_addr[q] % NB) == (wr_addr[w] % NB))
                        blocked = 1;
                e_wr[w] = run_now && wr_valid[w] && (wr_addr[w] >= DEPTH || !blocked);
                e_we[w] = e_wr[w] && (wr_addr[w] >= DEPTH);
            end
            chk("model_init_done", 64'(init_done), 64'(m_run));
            chk("model_rd_ready", 64'(rd_ready), 64'(e_rr));
            chk("model_wr_ready", 64'(wr_ready), 64'(e_wr));
            chk("model_wr_err", 64'(wr_err), 64'(e_we));
            chk("model_rd_resp_valid", 64'(rd_resp_valid), 64'(m_rvld));
            chk("model_rd_err", 64'(rd_err), 64'(m_rerr));
            for (int p = 0; p < NR; p++)
                chk($sformatf("model_rd_data%0d", p), 64'(rd_data[p]), 64'(m_rdata[p]));
            if (reset) begin
                m_cnt = 0; m_run = 0; m_rvld = '0; m_rerr = '0;
                for (int p = 0; p < NR; p++) m_rdata[p] = '0;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end else begin
                if (!m_run) begin
                    m_cnt++;
                    if (m_cnt == ROWS) m_run = 1;
                end
                for (int w = 0; w < NW; w++)
                    if (e_wr[w] && wr_addr[w] < DEPTH)
                        for (int k = 0; k < DW/8; k++)
                            if (wr_strb[w][k])
                                m_mem[wr_addr[w][IDXW-1:0]][8*k +: 8] = wr_data[w][8*k +: 8];
                for (int p = 0; p < NR; p++) begin
                    m_rvld[p] = e_rr[p];
                    m_rerr[p] = e_rr[p] && (rd_addr[p] >= DEPTH);
                    if (e_rr[p])
                        m_rdata[p] = (rd_addr[p] >= DEPTH) ? '0 : m_mem[rd_addr[p][IDXW-1:0]];
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        rd_valid = '0;
        wr_valid = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_valid[p] = 1'b1;
        rd_addr[p]  = a;
    endtask

    task automatic set_wr(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        wr_valid[w] = 1'b1;
        wr_addr[w]  = a;
        wr_data[w]  = d;
        wr_strb[w]  = s;
    endtask

    initial begin : stim
        reset = 1'b1;
        idle();
        rd_addr = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        repeat (3) tick();
        chk("reset_init_done", 64'(init_done), 64'd0);
        chk("reset_rd_resp_valid", 64'(rd_resp_valid), 64'd0);
        set_rd(0, 0);
        set_wr(0, 3, 32'h55, 4'hF);
        #2;
        chk("reset_rd_ready", 64'(rd_ready), 64'd0);
        chk("reset_wr_ready", 64'(wr_ready), 64'd0);
        tick();
        reset = 1'b0;
        #2;
        chk("init_rd_ready", 64'(rd_ready), 64'd0);
        chk("init_wr_ready", 64'(wr_ready), 64'd0);
        repeat (255) tick();
        chk("init_done_at_255", 64'(init_done), 64'd0);
        chk("init_rd_ready_late", 64'(rd_ready), 64'd0);
        idle();
        tick();
        chk("init_done_at_256", 64'(init_done), 64'd1);

        // Cleared memory reads back 0.
        set_rd(0, 37);
        #2 chk("rd37_ready", 64'(rd_ready), 64'b01);
        tick(); idle();
        chk("rd37_resp_valid", 64'(rd_resp_valid), 64'b01);
        chk("rd37_data", 64'(rd_data[0]), 64'd0);

        // Write then read on the other port.
        set_wr(0, 5, 32'hDEADBEEF, 4'hF);
        #2 chk("wr5_ready", 64'(wr_ready), 64'b01);
        tick(); idle();
        set_rd(1, 5);
        #2 chk("rd5_ready", 64'(rd_ready), 64'b10);
        tick(); idle();
        chk("rd5_resp_valid", 64'(rd_resp_valid), 64'b10);
        chk("rd5_data", 64'(rd_data[1]), 64'hDEADBEEF);
        chk("rd5_err", 64'(rd_err), 64'd0);
        tick();
        chk("rd5_hold_valid", 64'(rd_resp_valid), 64'd0);
        chk("rd5_hold_data", 64'(rd_data[1]), 64'hDEADBEEF);

        // Write-first collision with partial strobe.
        set_wr(0, 8, 32'h11223344, 4'hF);
        tick(); idle();
        set_wr(1, 8, 32'hAABBCCDD, 4'h3);
        set_rd(0, 8);
        #2;
        chk("coll_wr_ready", 64'(wr_ready), 64'b10);
        chk("coll_rd_ready", 64'(rd_ready), 64'b01);
        tick(); idle();
        chk("coll_rd_data", 64'(rd_data[0]), 64'h1122CCDD);
        set_rd(1, 8);
        tick(); idle();
        chk("coll_mem_data", 64'(rd_data[1]), 64'h1122CCDD);

        // Bank conflicts: writes to bank 0 collide, reads to banks 1/2 do not.
        set_wr(0, 4, 32'hA0A0A0A0, 4'hF);
        set_wr(1, 8, 32'hB1B1B1B1, 4'hF);
        set_rd(0, 1);
        set_rd(1, 2);
        #2;
        chk("conf_wr_ready", 64'(wr_ready), 64'b01);
        chk("conf_rd_ready", 64'(rd_ready), 64'b11);
        tick();
        wr_valid[0] = 1'b0;
        rd_valid = '0;
        chk("conf_rd_resp", 64'(rd_resp_valid), 64'b11);
        #2 chk("conf_wr1_retry", 64'(wr_ready), 64'b10);
        tick(); idle();
        set_rd(0, 4);
        set_rd(1, 8);
        #2 chk("conf_rdbank_ready", 64'(rd_ready), 64'b01);
        tick();
        rd_valid[0] = 1'b0;
        chk("conf_rd4_data", 64'(rd_data[0]), 64'hA0A0A0A0);
        #2 chk("conf_rd8_retry", 64'(rd_ready), 64'b10);
        tick(); idle();
        chk("conf_rd8_data", 64'(rd_data[1]), 64'hB1B1B1B1);
        set_wr(0, 12, 32'h0000_0001, 4'hF);
        set_wr(1, 12, 32'h0000_0002, 4'hF);
        #2 chk("same_addr_wr_ready", 64'(wr_ready), 64'b01);
        tick(); wr_valid[0] = 1'b0;
        tick(); idle();

        // Out of range: dropped write does not consume bank 0; read errors.
        set_wr(0, 1024, 32'hFFFFFFFF, 4'hF);
        set_wr(1, 0, 32'h12345678, 4'hF);
        #2;
        chk("oor_wr_ready", 64'(wr_ready), 64'b11);
        chk("oor_wr_err", 64'(wr_err), 64'b01);
        tick(); idle();
        set_rd(0, 2000);
        set_rd(1, 0);
        #2 chk("oor_rd_ready", 64'(rd_ready), 64'b11);
        tick(); idle();
        chk("oor_rd_resp", 64'(rd_resp_valid), 64'b11);
        chk("oor_rd_err", 64'(rd_err), 64'b01);
        chk("oor_rd_data", 64'(rd_data[0]), 64'd0);
        chk("oor_addr0_data", 64'(rd_data[1]), 64'h12345678);
        set_rd(0, 32'h8000_0005);
        tick(); idle();
        chk("hibit_rd_err", 64'(rd_err), 64'b01);
        chk("hibit_rd_data", 64'(rd_data[0]), 64'd0);

        // Reset mid-stream.
        set_rd(0, 5);
        tick(); idle();
        chk("pre_reset_data", 64'(rd_data[0]), 64'hDEADBEEF);
        set_rd(1, 5);
        reset = 1'b1;
        #2 chk("reset_mid_ready", 64'(rd_ready), 64'd0);
        tick(); idle();
        chk("reset_mid_resp", 64'(rd_resp_valid), 64'd0);
        chk("reset_mid_init_done", 64'(init_done), 64'd0);
        chk("reset_mid_data", 64'(rd_data[0]), 64'd0);
        tick();
        reset = 1'b0;
        repeat (255) tick();
        chk("reinit_done_255", 64'(init_done), 64'd0);
        tick();
        chk("reinit_done_256", 64'(init_done), 64'd1);
        set_rd(0, 5);
        tick(); idle();
        chk("reinit_rd5_resp", 64'(rd_resp_valid), 64'b01);
        chk("reinit_rd5_data", 64'(rd_data[0]), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
